// File: rtl/keycode_pkg.sv
// Shared constants, types and the key index -> HID usage table for the keycode packer.
// Configuration macro used by keycode_packer: KEYCODE_PACKER_ROLLOVER_ERR_EN.
package keycode_pkg;

  localparam int unsigned NUM_KEYS  = 16;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned KC_W      = 8;
  localparam int unsigned KEYCODE_W = KC_W * NUM_SLOTS;
  localparam int unsigned IDX_W     = $clog2(NUM_KEYS);

  localparam logic [KC_W-1:0] KC_EMPTY    = 8'h00;
  localparam logic [KC_W-1:0] KC_ROLLOVER = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CMP  = 2'd2,
    EMIT = 2'd3
  } packer_state_t;

  // Slot array as seen on the report: slot0 occupies the low byte.
  typedef logic [NUM_SLOTS-1:0][KC_W-1:0] slot_array_t;

  // Key flag index to USB HID usage code.
  function automatic logic [KC_W-1:0] key_to_hid(input logic [IDX_W-1:0] idx);
    logic [KC_W-1:0] code;
    case (idx)
      4'd0:    code = 8'h1A;  // w
      4'd1:    code = 8'h04;  // a
      4'd2:    code = 8'h16;  // s
      4'd3:    code = 8'h07;  // d
      4'd4:    code = 8'h09;  // f
      4'd5:    code = 8'h0B;  // h
      4'd6:    code = 8'h0D;  // j
      4'd7:    code = 8'h0E;  // k
      4'd8:    code = 8'h0F;  // l
      4'd9:    code = 8'h0C;  // i
      4'd10:   code = 8'h3A;  // F1
      4'd11:   code = 8'h3B;  // F2
      4'd12:   code = 8'h28;  // enter
      4'd13:   code = 8'h29;  // esc
      4'd14:   code = 8'h13;  // p
      4'd15:   code = 8'h14;  // q
      default: code = KC_EMPTY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keycode_slot_table.sv
// Press-ordered keycode slot array.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   ins_en      - write code into the lowest empty slot (ignored when full)
//   rem_en      - remove the slot holding code; higher slots shift down, top slot empties
//   code        - HID code for the operation (never KC_EMPTY)
//   slots       - registered slot contents, slot0 in the low byte
//   full_c      - combinational: every slot occupied
module keycode_slot_table
  import keycode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_en,
  input  logic              rem_en,
  input  logic [KC_W-1:0]   code,
  output slot_array_t       slots,
  output logic              full_c
);

  slot_array_t slot_q;
  slot_array_t slot_d;
  slot_array_t upper_c;

  // Each slot's replacement value for a shift-down.
  always_comb begin
    upper_c = '0;
    for (int i = 0; i < int'(NUM_SLOTS) - 1; i++) begin
      upper_c[i] = slot_q[i+1];
    end
    upper_c[NUM_SLOTS-1] = KC_EMPTY;
  end

  // Occupancy is kept compact, but check every slot anyway.
  always_comb begin
    full_c = 1'b1;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (slot_q[i] == KC_EMPTY) full_c = 1'b0;
    end
  end

  // Single operation per cycle; remove wins if both are requested.
  always_comb begin
    logic hit;
    logic placed;
    slot_d = slot_q;
    hit    = 1'b0;
    placed = 1'b0;
    if (rem_en) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (slot_q[i] == code) hit = 1'b1;
        if (hit) slot_d[i] = upper_c[i];
      end
    end else if (ins_en) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (!placed && slot_q[i] == KC_EMPTY) begin
          slot_d[i] = code;
          placed    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slots = slot_q;

endmodule

// File: rtl/keycode_packer.sv
// Packs per-key level flags into a 4-slot USB HID keycode report, slots in press
// order, and offers the report over valid/ready only when its contents change.
// Ports:
//   Clk, Reset    - clock and synchronous active-high reset
//   key_on        - NUM_KEYS level flags, 1 = key held
//   report_ready  - consumer accepts the report
//   report_valid  - report held stable until accepted
//   keycode       - slot0 = [7:0] ... slot3 = [31:24], 8'h00 = empty
//   slots_full    - all slots occupied (updated once per scan)
//   overflow      - at least one held key was dropped (updated once per scan)
// Configuration: define KEYCODE_PACKER_ROLLOVER_ERR_EN to report ErrorRollOver in
// every slot while overflow is set.
module keycode_packer
  import keycode_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_KEYS-1:0]  key_on,
  input  logic                 report_ready,
  output logic                 report_valid,
  output logic [KEYCODE_W-1:0] keycode,
  output logic                 slots_full,
  output logic                 overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  packer_state_t        state_q, state_d;
  logic [NUM_KEYS-1:0]  snap_q, snap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_KEYS-1:0]  held_q, held_d;
  logic [NUM_KEYS-1:0]  drop_q, drop_d;
  logic [KEYCODE_W-1:0] last_q, last_d;
  logic [KEYCODE_W-1:0] keycode_q, keycode_d;
  logic                 valid_q, valid_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;

  logic                 ins_en_c;
  logic                 rem_en_c;
  logic [KC_W-1:0]      code_c;
  slot_array_t          tbl_slots;
  logic                 tbl_full_c;
  logic [KEYCODE_W-1:0] word_c;

  keycode_slot_table u_slot_table (
    .clk    (Clk),
    .reset  (Reset),
    .ins_en (ins_en_c),
    .rem_en (rem_en_c),
    .code   (code_c),
    .slots  (tbl_slots),
    .full_c (tbl_full_c)
  );

  assign code_c = key_to_hid(idx_q);

  // Candidate report word built from the slot table.
`ifdef KEYCODE_PACKER_ROLLOVER_ERR_EN
  assign word_c = (|drop_q) ? {NUM_SLOTS{KC_ROLLOVER}} : KEYCODE_W'(tbl_slots);
`else
  assign word_c = KEYCODE_W'(tbl_slots);
`endif

  // State register and all registered outputs/bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      held_q    <= '0;
      drop_q    <= '0;
      last_q    <= '0;
      keycode_q <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      held_q    <= held_d;
      drop_q    <= drop_d;
      last_q    <= last_d;
      keycode_q <= keycode_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state, per-key scan rules, word compare and handshake.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    held_d    = held_q;
    drop_d    = drop_q;
    last_d    = last_q;
    keycode_d = keycode_q;
    valid_d   = valid_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    ins_en_c  = 1'b0;
    rem_en_c  = 1'b0;

    case (state_q)
      IDLE: begin
        snap_d  = key_on;
        idx_d   = '0;
        state_d = SCAN;
      end

      SCAN: begin
        // The table op lands at this edge, so the next index sees its effect.
        if (!snap_q[idx_q]) begin
          if (held_q[idx_q]) begin
            rem_en_c      = 1'b1;
            held_d[idx_q] = 1'b0;
          end else if (drop_q[idx_q]) begin
            drop_d[idx_q] = 1'b0;
          end
        end else if (!held_q[idx_q] && !drop_q[idx_q]) begin
          if (!tbl_full_c) begin
            ins_en_c      = 1'b1;
            held_d[idx_q] = 1'b1;
          end else begin
            drop_d[idx_q] = 1'b1;
          end
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = CMP;
      end

      CMP: begin
        full_d = tbl_full_c;
        ovf_d  = |drop_q;
        if (word_c != last_q) begin
          keycode_d = word_c;
          valid_d   = 1'b1;
          state_d   = EMIT;
        end else begin
          state_d = IDLE;
        end
      end

      EMIT: begin
        if (report_ready) begin
          last_d  = keycode_q;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign report_valid = valid_q;
  assign keycode      = keycode_q;
  assign slots_full   = full_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_keycode_packer.sv
// Scoreboard bench for keycode_packer: expected reports are queued as key states
// are applied and compared on every accepted handshake.
module tb_keycode_packer;
  import keycode_pkg::*;

  typedef struct packed {
    logic [31:0] word;
    logic        full;
    logic        ovf;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] key_on = '0;
  logic        report_ready = 1'b0;
  logic        report_valid;
  logic [31:0] keycode;
  logic        slots_full;
  logic        overflow;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  localparam logic [15:0] K_W = 16'h0001, K_A = 16'h0002, K_S = 16'h0004,
                          K_D = 16'h0008, K_F = 16'h0010, K_J = 16'h0040,
                          K_K = 16'h0080, K_L = 16'h0100, K_ENT = 16'h1000,
                          K_Q = 16'h8000;

  keycode_packer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .key_on       (key_on),
    .report_ready (report_ready),
    .report_valid (report_valid),
    .keycode      (keycode),
    .slots_full   (slots_full),
    .overflow     (overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic f, input logic o);
    exp_t e;
    e.word = w;
    e.full = f;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  // Wait for all queued reports to be accepted, then idle long enough to catch extras.
  task automatic settle(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 120) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (45) tick();
  endtask

  task automatic step(input string tag, input logic [15:0] keys, input bit rpt,
                      input logic [31:0] w, input logic f, input logic o);
    if (rpt) push(w, f, o);
    key_on = keys;
    settle(tag);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!report_valid && n < 120) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(report_valid), 32'd1);
  endtask

  // Scoreboard side: compare every accepted report against the queue head.
  always @(negedge Clk) begin
    if (!Reset && report_valid && report_ready) begin
      check("report_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("report_word", keycode, e.word);
        check("report_full", 32'(slots_full), 32'(e.full));
        check("report_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    int lat;
    logic [31:0] held_word;

    repeat (3) tick();
    check("rst_valid", 32'(report_valid), 32'd0);
    check("rst_keycode", keycode, 32'd0);
    check("rst_full", 32'(slots_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // First report latency from the first IDLE snapshot.
    key_on = K_W;
    report_ready = 1'b1;
    push(32'h0000001A, 1'b0, 1'b0);
    Reset = 1'b0;
    lat = 0;
    while (!report_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("latency_w", 32'(lat <= 19), 32'd1);
    settle("w_only");

    step("rel_w", 16'h0, 1, 32'h00000000, 1'b0, 1'b0);
    step("press_a", K_A, 1, 32'h00000004, 1'b0, 1'b0);
    step("add_d", K_A | K_D, 1, 32'h00000704, 1'b0, 1'b0);
    step("rel_a", K_D, 1, 32'h00000007, 1'b0, 1'b0);
    step("rel_all1", 16'h0, 1, 32'h00000000, 1'b0, 1'b0);
    step("w_q_same", K_W | K_Q, 1, 32'h0000141A, 1'b0, 1'b0);
    step("rel_all2", 16'h0, 1, 32'h00000000, 1'b0, 1'b0);

    // Five keys into four slots; f drops.
`ifdef KEYCODE_PACKER_ROLLOVER_ERR_EN
    step("five", K_W | K_A | K_S | K_D | K_F, 1, 32'h01010101, 1'b1, 1'b1);
    step("rel_d_keep_f", K_W | K_A | K_S | K_F, 0, 32'h0, 1'b0, 1'b0);
    check("rel_d_ovf", 32'(overflow), 32'd1);
    check("rel_d_full", 32'(slots_full), 32'd0);
    step("rel_f", K_W | K_A | K_S, 1, 32'h0016041A, 1'b0, 1'b0);
`else
    step("five", K_W | K_A | K_S | K_D | K_F, 1, 32'h0716041A, 1'b1, 1'b1);
    step("rel_d_keep_f", K_W | K_A | K_S | K_F, 1, 32'h0016041A, 1'b0, 1'b1);
    step("rel_f", K_W | K_A | K_S, 0, 32'h0, 1'b0, 1'b0);
    check("rel_f_ovf", 32'(overflow), 32'd0);
    check("rel_f_word", keycode, 32'h0016041A);
`endif
    step("repress_f", K_W | K_A | K_S | K_F, 1, 32'h0916041A, 1'b1, 1'b0);

    // A lower-index release frees a slot for a higher-index press in one scan.
    step("rel_all3", 16'h0, 1, 32'h00000000, 1'b0, 1'b0);
    step("four", K_W | K_A | K_S | K_D, 1, 32'h0716041A, 1'b1, 1'b0);
    step("swap_a_f", K_W | K_S | K_D | K_F, 1, 32'h0907161A, 1'b1, 1'b0);
    step("rel_all4", 16'h0, 1, 32'h00000000, 1'b0, 1'b0);

    // Backpressure: report holds while key_on toggles.
    report_ready = 1'b0;
    push(32'h0000000D, 1'b0, 1'b0);
    key_on = K_J;
    wait_valid("bp");
    held_word = keycode;
    check("bp_word", held_word, 32'h0000000D);
    for (int i = 0; i < 50; i++) begin
      key_on = 16'($urandom);
      tick();
      check("bp_valid_hold", 32'(report_valid), 32'd1);
      check("bp_word_hold", keycode, 32'h0000000D);
    end
    key_on = K_K | K_L;
    push(32'h00000F0E, 1'b0, 1'b0);
    report_ready = 1'b1;
    settle("bp_release");

    // Reset in EMIT discards the pending report.
    step("rel_all5", 16'h0, 1, 32'h00000000, 1'b0, 1'b0);
    report_ready = 1'b0;
    key_on = K_ENT;
    wait_valid("rst_emit");
    Reset = 1'b1;
    tick();
    check("rst_emit_valid", 32'(report_valid), 32'd0);
    check("rst_emit_keycode", keycode, 32'd0);
    push(32'h00000028, 1'b0, 1'b0);
    report_ready = 1'b1;
    Reset = 1'b0;
    settle("rst_rereport");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
